// File: rtl/rd_data_checker.sv
// rd_data_checker: read-back checker for the DDR3 read FIFO output.
//
// Compares every accepted read word against the incrementing pattern
// EXP_INIT..EXP_LAST (wrapping back to EXP_INIT) written by the test data
// generator. It counts words, mismatches and completed passes, captures the
// first mismatch and holds a sticky error flag for ILA/LED observation.
//
// Optional feature, controlled by the CHK_RESYNC_EN macro:
//   defined   - after a mismatch the expected value resyncs to the received
//               word + 1, so one dropped or duplicated word costs one error.
//   undefined - the expected value advances independently of the data, so a
//               slip reports an error on every following word.
//
// All outputs come straight from flops. For a word presented with rd_valid in
// cycle N, the compare result becomes visible in cycle N+1.

module rd_data_checker #(
    parameter int unsigned       DATA_W   = 16,
    parameter logic [DATA_W-1:0] EXP_INIT = '0,
    parameter logic [DATA_W-1:0] EXP_LAST = DATA_W'(2200),
    parameter int unsigned       ERR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calib_done,
    input  logic              clr,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              chk_active,
    output logic              err_pulse,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [31:0]       word_cnt,
    output logic [15:0]       pass_cnt,
    output logic [31:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act
);

    // Two-state control: checking is only live once DDR3 calibration is done.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_e;

    state_e            state_q, state_d;

    logic              err_pulse_q, err_pulse_d;
    logic              err_flag_q, err_flag_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [31:0]       first_err_idx_q, first_err_idx_d;
    logic [DATA_W-1:0] first_err_exp_q, first_err_exp_d;
    logic [DATA_W-1:0] first_err_act_q, first_err_act_d;
    logic [DATA_W-1:0] exp_q, exp_d;

    // A word is compared only in CHECK with calibration still high; a
    // simultaneous clr discards it.
    logic              accept;
    logic              mismatch;
    logic [DATA_W-1:0] pos;

    assign accept   = (state_q == S_CHECK) && calib_done && rd_valid && !clr;
    assign mismatch = (rd_data != exp_q);

    // Position in the pattern that the next expected value advances from.
`ifdef CHK_RESYNC_EN
    assign pos = mismatch ? rd_data : exp_q;
`else
    assign pos = exp_q;
`endif

    // Next-state logic for the IDLE/CHECK controller.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (calib_done)  state_d = S_CHECK;
            S_CHECK: if (!calib_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Compare datapath: counters, first-error capture and expected-value advance.
    always_comb begin
        err_pulse_d     = 1'b0;
        err_flag_d      = err_flag_q;
        err_cnt_d       = err_cnt_q;
        word_cnt_d      = word_cnt_q;
        pass_cnt_d      = pass_cnt_q;
        first_err_idx_d = first_err_idx_q;
        first_err_exp_d = first_err_exp_q;
        first_err_act_d = first_err_act_q;
        exp_d           = exp_q;

        if (clr) begin
            err_flag_d      = 1'b0;
            err_cnt_d       = '0;
            word_cnt_d      = '0;
            pass_cnt_d      = '0;
            first_err_idx_d = '0;
            first_err_exp_d = '0;
            first_err_act_d = '0;
            exp_d           = EXP_INIT;
        end else if (accept) begin
            word_cnt_d = word_cnt_q + 32'd1;

            if (mismatch) begin
                err_pulse_d = 1'b1;
                err_flag_d  = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                // Only the first mismatch since rst/clr is captured.
                if (!err_flag_q) begin
                    first_err_idx_d = word_cnt_q;
                    first_err_exp_d = exp_q;
                    first_err_act_d = rd_data;
                end
            end

            // Pass boundary is counted by position, whether or not it matched.
            if (pos == EXP_LAST) begin
                exp_d      = EXP_INIT;
                pass_cnt_d = pass_cnt_q + 16'd1;
            end else begin
                exp_d = pos + DATA_W'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q         <= S_IDLE;
            err_pulse_q     <= 1'b0;
            err_flag_q      <= 1'b0;
            err_cnt_q       <= '0;
            word_cnt_q      <= '0;
            pass_cnt_q      <= '0;
            first_err_idx_q <= '0;
            first_err_exp_q <= '0;
            first_err_act_q <= '0;
            exp_q           <= EXP_INIT;
        end else begin
            state_q         <= state_d;
            err_pulse_q     <= err_pulse_d;
            err_flag_q      <= err_flag_d;
            err_cnt_q       <= err_cnt_d;
            word_cnt_q      <= word_cnt_d;
            pass_cnt_q      <= pass_cnt_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_exp_q <= first_err_exp_d;
            first_err_act_q <= first_err_act_d;
            exp_q           <= exp_d;
        end
    end

    assign chk_active    = (state_q == S_CHECK);
    assign err_pulse     = err_pulse_q;
    assign err_flag      = err_flag_q;
    assign err_cnt       = err_cnt_q;
    assign word_cnt      = word_cnt_q;
    assign pass_cnt      = pass_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_exp = first_err_exp_q;
    assign first_err_act = first_err_act_q;

endmodule

// File: tb/tb_rd_data_checker.sv
// Self-checking bench for rd_data_checker.
// Stimulus pushes the expected per-word result into a scoreboard queue; an
// independent monitor pops and compares whenever the DUT's word counter
// advances. Directed end-of-phase checks use hand-computed constants.
// A second instance with ERR_W=4 shares the stimulus for the saturation case.

module tb_rd_data_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        calib_done;
    logic        clr;
    logic        rd_valid;
    logic [15:0] rd_data;

    logic        chk_active, err_pulse, err_flag;
    logic [15:0] err_cnt;
    logic [31:0] word_cnt;
    logic [15:0] pass_cnt;
    logic [31:0] first_err_idx;
    logic [15:0] first_err_exp, first_err_act;

    logic        s_chk_active, s_err_pulse, s_err_flag;
    logic [3:0]  s_err_cnt;
    logic [31:0] s_word_cnt;
    logic [15:0] s_pass_cnt;
    logic [31:0] s_first_err_idx;
    logic [15:0] s_first_err_exp, s_first_err_act;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] wcnt;
        logic [15:0] ecnt;
    } exp_t;

    exp_t sb_q[$];

    // Small reference model of the pattern position and counters.
    logic [15:0] m_exp;
    logic [31:0] m_word;
    logic [15:0] m_err;

    always #5 clk = ~clk;

    rd_data_checker #(
        .DATA_W  (16),
        .EXP_INIT(16'd0),
        .EXP_LAST(16'd2200),
        .ERR_W   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .calib_done   (calib_done),
        .clr          (clr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .chk_active   (chk_active),
        .err_pulse    (err_pulse),
        .err_flag     (err_flag),
        .err_cnt      (err_cnt),
        .word_cnt     (word_cnt),
        .pass_cnt     (pass_cnt),
        .first_err_idx(first_err_idx),
        .first_err_exp(first_err_exp),
        .first_err_act(first_err_act)
    );

    rd_data_checker #(
        .DATA_W  (16),
        .EXP_INIT(16'd0),
        .EXP_LAST(16'd2200),
        .ERR_W   (4)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .calib_done   (calib_done),
        .clr          (clr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .chk_active   (s_chk_active),
        .err_pulse    (s_err_pulse),
        .err_flag     (s_err_flag),
        .err_cnt      (s_err_cnt),
        .word_cnt     (s_word_cnt),
        .pass_cnt     (s_pass_cnt),
        .first_err_idx(s_first_err_idx),
        .first_err_exp(s_first_err_exp),
        .first_err_act(s_first_err_act)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_exp  = 16'd0;
        m_word = 32'd0;
        m_err  = 16'd0;
    endtask

    // Present one word that the DUT is expected to accept and compare.
    task automatic send(input logic [15:0] d);
        exp_t        e;
        logic        bad;
        logic [15:0] p;
        bad = (d != m_exp);
        m_word = m_word + 32'd1;
        if (bad && m_err != 16'hFFFF) m_err = m_err + 16'd1;
`ifdef CHK_RESYNC_EN
        p = bad ? d : m_exp;
`else
        p = m_exp;
`endif
        m_exp = (p == 16'd2200) ? 16'd0 : p + 16'd1;
        e.err  = bad;
        e.wcnt = m_word;
        e.ecnt = m_err;
        sb_q.push_back(e);
        rd_valid = 1'b1;
        rd_data  = d;
        tick();
    endtask

    task automatic idle();
        rd_valid = 1'b0;
        rd_data  = 16'h0000;
        tick();
    endtask

    task automatic pulse_clr();
        rd_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_reset();
    endtask

    // Monitor: one scoreboard entry per observed word_cnt advance.
    initial begin : monitor
        logic [31:0] prev_wc;
        exp_t        e;
        prev_wc = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (word_cnt == prev_wc + 32'd1) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_word", 64'(word_cnt), 64'(prev_wc));
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_err_pulse", 64'(err_pulse), 64'(e.err));
                        check("sb_word_cnt", 64'(word_cnt), 64'(e.wcnt));
                        check("sb_err_cnt", 64'(err_cnt), 64'(e.ecnt));
                    end
                end else if (err_pulse !== 1'b0) begin
                    check("stray_err_pulse", 64'(err_pulse), 64'd0);
                end
            end
            prev_wc = word_cnt;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst        = 1'b1;
        calib_done = 1'b0;
        clr        = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 16'h0000;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Reset state.
        check("rst_chk_active", 64'(chk_active), 64'd0);
        check("rst_err_pulse", 64'(err_pulse), 64'd0);
        check("rst_err_flag", 64'(err_flag), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_word_cnt", 64'(word_cnt), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_first_idx", 64'(first_err_idx), 64'd0);
        check("rst_first_exp", 64'(first_err_exp), 64'd0);
        check("rst_first_act", 64'(first_err_act), 64'd0);

        // Words before calibration are ignored.
        rd_valid = 1'b1;
        rd_data  = 16'h0000;
        tick();
        rd_valid = 1'b0;
        check("precal_word_cnt", 64'(word_cnt), 64'd0);

        calib_done = 1'b1;
        tick();
        check("cal_chk_active", 64'(chk_active), 64'd1);

        // Full pass 0..2200 back-to-back.
        for (int i = 0; i <= 2200; i++) send(16'(i));
        idle();
        check("t1_word_cnt", 64'(word_cnt), 64'd2201);
        check("t1_pass_cnt", 64'(pass_cnt), 64'd1);
        check("t1_err_cnt", 64'(err_cnt), 64'd0);
        check("t1_err_flag", 64'(err_flag), 64'd0);

        // Single corrupted word at index 5.
        pulse_clr();
        check("clr_word_cnt", 64'(word_cnt), 64'd0);
        check("clr_pass_cnt", 64'(pass_cnt), 64'd0);
        for (int i = 0; i < 10; i++) send((i == 5) ? 16'hDEAD : 16'(i));
        idle();
        check("t2_err_cnt", 64'(err_cnt), 64'd1);
        check("t2_err_flag", 64'(err_flag), 64'd1);
        check("t2_first_idx", 64'(first_err_idx), 64'd5);
        check("t2_first_exp", 64'(first_err_exp), 64'd5);
        check("t2_first_act", 64'(first_err_act), 64'hDEAD);
        check("t2_word_cnt", 64'(word_cnt), 64'd10);

        // Dropped word 3.
        pulse_clr();
        check("clr_err_flag", 64'(err_flag), 64'd0);
        check("clr_first_act", 64'(first_err_act), 64'd0);
        send(16'd0); send(16'd1); send(16'd2);
        send(16'd4); send(16'd5); send(16'd6);
        idle();
`ifdef CHK_RESYNC_EN
        check("t3_err_cnt", 64'(err_cnt), 64'd1);
`else
        check("t3_err_cnt", 64'(err_cnt), 64'd3);
`endif
        check("t3_first_idx", 64'(first_err_idx), 64'd3);
        check("t3_first_exp", 64'(first_err_exp), 64'd3);
        check("t3_first_act", 64'(first_err_act), 64'd4);

        // clr coinciding with a valid word: the word is discarded.
        pulse_clr();
        for (int i = 0; i < 7; i++) send(16'(i));
        rd_valid = 1'b1;
        rd_data  = 16'd7;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        rd_valid = 1'b0;
        model_reset();
        check("t4_word_cnt", 64'(word_cnt), 64'd0);
        check("t4_err_cnt", 64'(err_cnt), 64'd0);
        check("t4_pass_cnt", 64'(pass_cnt), 64'd0);
        check("t4_err_pulse", 64'(err_pulse), 64'd0);
        check("t4_chk_active", 64'(chk_active), 64'd1);
        send(16'd0);
        idle();
        check("t4_restart_word", 64'(word_cnt), 64'd1);
        check("t4_restart_err", 64'(err_cnt), 64'd0);

        // Calibration drop: words in IDLE are ignored, exp holds.
        send(16'd1); send(16'd2);
        idle();
        calib_done = 1'b0;
        tick();
        check("t5_idle", 64'(chk_active), 64'd0);
        rd_valid = 1'b1;
        for (int i = 3; i < 6; i++) begin
            rd_data = 16'(i);
            tick();
        end
        rd_valid = 1'b0;
        check("t5_ignored_words", 64'(word_cnt), 64'd3);
        calib_done = 1'b1;
        tick();
        check("t5_recheck", 64'(chk_active), 64'd1);
        send(16'd3); send(16'd4); send(16'd5);
        idle();
        check("t5_word_cnt", 64'(word_cnt), 64'd6);
        check("t5_err_cnt", 64'(err_cnt), 64'd0);
        check("t5_err_flag", 64'(err_flag), 64'd0);

        // Error counter saturation on the ERR_W=4 instance.
        pulse_clr();
        for (int i = 0; i < 20; i++) send(16'hBEEF);
        idle();
        check("t6_sat_err_cnt", 64'(s_err_cnt), 64'd15);
        check("t6_sat_word_cnt", 64'(s_word_cnt), 64'd20);
        check("t6_sat_err_flag", 64'(s_err_flag), 64'd1);
        check("t6_wide_err_cnt", 64'(err_cnt), 64'd20);

        idle();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
